// File: rtl/st7789_spi_monitor.sv
// Passive monitor for an ST7789 4-wire SPI panel bus. Recovers command/data
// bytes and presents them on an AXI-Stream master with end-of-burst marking.
module st7789_spi_monitor #(
   parameter int IDLE_TIMEOUT = 64,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       LCD_SCK,
   input  logic       LCD_SDA,
   input  logic       LCD_DC,
   input  logic       LCD_RST,
   output logic [7:0] M_AXIS_TDATA,
   output logic       M_AXIS_TKEEP,
   output logic       M_AXIS_TUSER,
   output logic       M_AXIS_TVALID,
   output logic       M_AXIS_TLAST,
   input  logic       M_AXIS_TREADY,
   output logic       OVERFLOW,
   output logic       FRAME_ERR
);

   localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(IDLE_TIMEOUT);
   localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

   typedef enum logic [1:0] {
      RST_ST   = 2'd0,
      IDLE_ST  = 2'd1,
      SHIFT_ST = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sck_sync_r;
   logic [SYNC_STAGES-1:0] sda_sync_r;
   logic [SYNC_STAGES-1:0] dc_sync_r;
   logic [SYNC_STAGES-1:0] rst_sync_r;
   logic                   sck_prev_r;

   logic       sck_s;
   logic       sda_s;
   logic       dc_s;
   logic       lcd_rst_s;
   logic       rise_s;

   state_t     state_r;
   state_t     state_s;
   logic       shift_en_s;
   logic       byte_done_s;
   logic       frame_err_s;

   logic [7:0]       shift_r;
   logic [2:0]       bit_cnt_r;
   logic [CNT_W-1:0] idle_cnt_r;
   logic             idle_hit_s;

   logic       pend_valid_r;
   logic       pend_res_r;
   logic       pend_last_r;
   logic [7:0] pend_data_r;
   logic       pend_user_r;
   logic       pend_move_s;

   logic       out_valid_r;
   logic       out_last_r;
   logic [7:0] out_data_r;
   logic       out_user_r;
   logic       overflow_r;
   logic       frame_err_r;

   assign sck_s      = sck_sync_r[SYNC_STAGES-1];
   assign sda_s      = sda_sync_r[SYNC_STAGES-1];
   assign dc_s       = dc_sync_r[SYNC_STAGES-1];
   assign lcd_rst_s  = rst_sync_r[SYNC_STAGES-1];
   assign rise_s     = sck_s & ~sck_prev_r;
   assign idle_hit_s = (idle_cnt_r == TIMEOUT_C);

   // Input synchronizers plus the extra SCK copy used for edge detection
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         sck_sync_r <= '1;
         sda_sync_r <= '1;
         dc_sync_r  <= '1;
         rst_sync_r <= '1;
         sck_prev_r <= 1'b1;
      end else begin
         sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], LCD_SCK};
         sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], LCD_SDA};
         dc_sync_r  <= {dc_sync_r[SYNC_STAGES-2:0], LCD_DC};
         rst_sync_r <= {rst_sync_r[SYNC_STAGES-2:0], LCD_RST};
         sck_prev_r <= sck_s;
      end
   end

   // Receiver state register
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_r <= RST_ST;
      end else begin
         state_r <= state_s;
      end
   end

   // Receiver next-state and per-cycle strobes
   always_comb begin
      state_s     = state_r;
      shift_en_s  = 1'b0;
      byte_done_s = 1'b0;
      frame_err_s = 1'b0;
      case (state_r)
         RST_ST: begin
            if (lcd_rst_s) begin
               state_s = IDLE_ST;
            end else begin
               state_s = RST_ST;
            end
         end
         IDLE_ST: begin
            if (!lcd_rst_s) begin
               state_s = RST_ST;
            end else if (rise_s) begin
               shift_en_s = 1'b1;
               state_s    = SHIFT_ST;
            end else begin
               state_s = IDLE_ST;
            end
         end
         SHIFT_ST: begin
            if (!lcd_rst_s) begin
               state_s = RST_ST;
            end else if (rise_s) begin
               shift_en_s = 1'b1;
               if (bit_cnt_r == 3'd7) begin
                  byte_done_s = 1'b1;
                  state_s     = IDLE_ST;
               end else begin
                  state_s = SHIFT_ST;
               end
            end else if (idle_hit_s) begin
               frame_err_s = 1'b1;
               state_s     = IDLE_ST;
            end else begin
               state_s = SHIFT_ST;
            end
         end
         default: begin
            state_s = RST_ST;
         end
      endcase
   end

   // Shift register and bit counter; partial bits are dropped on panel reset or timeout
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         shift_r   <= 8'h00;
         bit_cnt_r <= 3'd0;
      end else if (!lcd_rst_s || frame_err_s) begin
         shift_r   <= 8'h00;
         bit_cnt_r <= 3'd0;
      end else if (shift_en_s) begin
         shift_r   <= {shift_r[6:0], sda_s};
         bit_cnt_r <= bit_cnt_r + 3'd1;
      end else begin
         shift_r   <= shift_r;
         bit_cnt_r <= bit_cnt_r;
      end
   end

   // Idle counter: cycles since the last SCK rising edge, saturating
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         idle_cnt_r <= '0;
      end else if (rise_s) begin
         idle_cnt_r <= '0;
      end else if (!idle_hit_s) begin
         idle_cnt_r <= idle_cnt_r + ONE_C;
      end else begin
         idle_cnt_r <= idle_cnt_r;
      end
   end

   // A resolved pending byte may move out when the output slot is free or draining
   assign pend_move_s = lcd_rst_s & pend_valid_r & pend_res_r &
                        (~out_valid_r | M_AXIS_TREADY);

   // PENDING holds one completed byte until we know whether it ends the burst
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         pend_valid_r <= 1'b0;
         pend_res_r   <= 1'b0;
         pend_last_r  <= 1'b0;
         pend_data_r  <= 8'h00;
         pend_user_r  <= 1'b0;
      end else if (!lcd_rst_s) begin
         pend_valid_r <= 1'b0;
         pend_res_r   <= 1'b0;
         pend_last_r  <= 1'b0;
      end else if (byte_done_s && (!pend_valid_r || pend_move_s)) begin
         pend_valid_r <= 1'b1;
         pend_res_r   <= 1'b0;
         pend_last_r  <= 1'b0;
         pend_data_r  <= {shift_r[6:0], sda_s};
         pend_user_r  <= dc_s;
      end else if (pend_move_s) begin
         pend_valid_r <= 1'b0;
         pend_res_r   <= 1'b0;
      end else if (pend_valid_r && !pend_res_r && rise_s) begin
         pend_res_r  <= 1'b1;
         pend_last_r <= 1'b0;
      end else if (pend_valid_r && !pend_res_r && idle_hit_s) begin
         pend_res_r  <= 1'b1;
         pend_last_r <= 1'b1;
      end else begin
         pend_valid_r <= pend_valid_r;
         pend_res_r   <= pend_res_r;
         pend_last_r  <= pend_last_r;
      end
   end

   // AXI-Stream output register; survives panel reset so an issued beat completes
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         out_data_r  <= 8'h00;
         out_user_r  <= 1'b0;
      end else if (pend_move_s) begin
         out_valid_r <= 1'b1;
         out_last_r  <= pend_last_r;
         out_data_r  <= pend_data_r;
         out_user_r  <= pend_user_r;
      end else if (M_AXIS_TREADY) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // Sticky error flags, cleared only by RESETN
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         overflow_r  <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         if (byte_done_s && pend_valid_r && !pend_move_s) begin
            overflow_r <= 1'b1;
         end else begin
            overflow_r <= overflow_r;
         end
         if (frame_err_s) begin
            frame_err_r <= 1'b1;
         end else begin
            frame_err_r <= frame_err_r;
         end
      end
   end

   assign M_AXIS_TDATA  = out_data_r;
   assign M_AXIS_TKEEP  = 1'b1;
   assign M_AXIS_TUSER  = out_user_r;
   assign M_AXIS_TVALID = out_valid_r;
   assign M_AXIS_TLAST  = out_last_r;
   assign OVERFLOW      = overflow_r;
   assign FRAME_ERR     = frame_err_r;

endmodule
